bit_serializer: RTL and testbench

//   Upstream feeder for the serial pattern detector. Accepts parallel words over a

---
 rtl/bit_serializer_if.sv | 23 ++
 rtl/bit_serializer.sv | 132 +++++++++++++
 tb/tb_bit_serializer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/bit_serializer_if.sv
// Handshake and serial-output bundle between a word source and bit_serializer.
// The master side offers words; the slave side returns ready and the serial stream.
interface bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             data;
  logic             bit_valid;
  logic             busy;
  logic             done;

  modport master (
    output load_data, load_valid,
    input  load_ready, data, bit_valid, busy, done
  );

  modport slave (
    input  load_data, load_valid,
    output load_ready, data, bit_valid, busy, done
  );
endinterface

// File: rtl/bit_serializer.sv
// MSB-first parallel-to-serial shifter with a one-word holding buffer; 1 clk load-to-MSB latency.
// Optional macro SERIALIZER_PARITY_EN appends an even-parity bit; load_ready = !buf_full (registered).
module bit_serializer #(
  parameter int WIDTH    = 8,
  parameter bit IDLE_BIT = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  bit_serializer_if.slave bus
);
  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic             buf_full_q, buf_full_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             data_q, data_d;
  logic             bit_valid_q, bit_valid_d;
  logic             done_q, done_d;

  logic             accept;
  logic             final_bit;
  logic             free;
  logic [CW-1:0]    cnt_inc;
  logic [WIDTH-1:0] reload_word;

`ifdef SERIALIZER_PARITY_EN
  logic par_q, par_d;
  assign final_bit = (state_q == PARITY);
`else
  assign final_bit = (state_q == SHIFT) && (cnt_q == LAST);
`endif

  assign accept      = bus.load_valid && !buf_full_q;
  assign free        = (state_q == IDLE) || final_bit;
  assign cnt_inc     = cnt_q + 1'b1;
  // A buffered word always wins the reload; load_ready is low while it is held.
  assign reload_word = buf_full_q ? buf_q : bus.load_data;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    cnt_d       = cnt_q;
    data_d      = IDLE_BIT;
    bit_valid_d = 1'b0;
    done_d      = 1'b0;
`ifdef SERIALIZER_PARITY_EN
    par_d       = par_q;
`endif

    if (free && (buf_full_q || accept)) begin
      state_d     = SHIFT;
      data_d      = reload_word[WIDTH-1];
      shift_d     = {reload_word[WIDTH-2:0], 1'b0};
      cnt_d       = '0;
      bit_valid_d = 1'b1;
      buf_full_d  = 1'b0;
`ifdef SERIALIZER_PARITY_EN
      par_d       = ^reload_word;
`endif
    end else if (free) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      if (accept) begin
        buf_d      = bus.load_data;
        buf_full_d = 1'b1;
      end
      bit_valid_d = 1'b1;
`ifdef SERIALIZER_PARITY_EN
      if (cnt_q == LAST) begin
        state_d = PARITY;
        data_d  = par_q;
        done_d  = 1'b1;
      end else begin
        data_d  = shift_q[WIDTH-1];
        shift_d = {shift_q[WIDTH-2:0], 1'b0};
        cnt_d   = cnt_inc;
      end
`else
      data_d  = shift_q[WIDTH-1];
      shift_d = {shift_q[WIDTH-2:0], 1'b0};
      cnt_d   = cnt_inc;
      done_d  = (cnt_inc == LAST);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      cnt_q       <= '0;
      data_q      <= IDLE_BIT;
      bit_valid_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      bit_valid_q <= bit_valid_d;
      done_q      <= done_d;
`ifdef SERIALIZER_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  assign bus.load_ready = !buf_full_q;
  assign bus.data       = data_q;
  assign bus.bit_valid  = bit_valid_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;
endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: an 8-bit and a 5-bit instance share clock and reset.
module tb_bit_serializer;
`ifdef SERIALIZER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int L8 = 8 + PAR;
  localparam int L5 = 5 + PAR;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  bit_serializer_if #(.WIDTH(8)) if8 ();
  bit_serializer_if #(.WIDTH(5)) if5 ();

  bit_serializer #(.WIDTH(8), .IDLE_BIT(1'b0)) u8 (.clk(clk), .rst(rst), .bus(if8.slave));
  bit_serializer #(.WIDTH(5), .IDLE_BIT(1'b0)) u5 (.clk(clk), .rst(rst), .bus(if5.slave));

  function automatic logic bit8(input logic [7:0] w, input int j);
    if (j < 8) return w[7-j];
    return ^w;
  endfunction

  function automatic logic bit5(input logic [4:0] w, input int j);
    if (j < 5) return w[4-j];
    return ^w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    n_vec++; if ({if8.data, if8.bit_valid, if8.busy, if8.done, if8.load_ready} !== 5'b00001) begin
      n_err++; $display("FAIL reset8 got %b want 00001", {if8.data, if8.bit_valid, if8.busy, if8.done, if8.load_ready});
    end
    n_vec++; if ({if5.data, if5.bit_valid, if5.busy, if5.done, if5.load_ready} !== 5'b00001) begin
      n_err++; $display("FAIL reset5 got %b want 00001", {if5.data, if5.bit_valid, if5.busy, if5.done, if5.load_ready});
    end
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  // 5'b10101 accepted at one edge: bits 1,0,1,0,1 on the next cycles, done on the last
  task automatic test_single5();
    if5.load_data  = 5'b10101;
    if5.load_valid = 1'b1;
    tick();
    if5.load_valid = 1'b0;
    for (int j = 0; j < L5; j++) begin
      n_vec++; if (if5.data !== bit5(5'b10101, j) || if5.bit_valid !== 1'b1 || if5.busy !== 1'b1) begin
        n_err++; $display("FAIL single5 bit%0d got d=%b v=%b b=%b want d=%b v=1 b=1", j, if5.data, if5.bit_valid, if5.busy, bit5(5'b10101, j));
      end
      n_vec++; if (if5.done !== (j == L5 - 1)) begin
        n_err++; $display("FAIL single5_done bit%0d got %b want %b", j, if5.done, (j == L5 - 1));
      end
      tick();
    end
    n_vec++; if ({if5.data, if5.bit_valid, if5.busy, if5.done, if5.load_ready} !== 5'b00001) begin
      n_err++; $display("FAIL single5_idle got %b want 00001", {if5.data, if5.bit_valid, if5.busy, if5.done, if5.load_ready});
    end
  endtask

  task automatic test_single8(input logic [7:0] w);
    if8.load_data  = w;
    if8.load_valid = 1'b1;
    tick();
    if8.load_valid = 1'b0;
    for (int j = 0; j < L8; j++) begin
      n_vec++; if (if8.data !== bit8(w, j) || if8.bit_valid !== 1'b1 || if8.done !== (j == L8 - 1)) begin
        n_err++; $display("FAIL single8 w=%h bit%0d got d=%b v=%b dn=%b want d=%b v=1 dn=%b", w, j, if8.data, if8.bit_valid, if8.done, bit8(w, j), (j == L8 - 1));
      end
      tick();
    end
    n_vec++; if ({if8.data, if8.bit_valid, if8.busy, if8.done} !== 4'b0000) begin
      n_err++; $display("FAIL single8_idle got %b want 0000", {if8.data, if8.bit_valid, if8.busy, if8.done});
    end
  endtask

  // A5 then 3C while busy, then F0 offered with the buffer full: contiguous stream
  task automatic test_back_to_back();
    logic [7:0] words [3];
    logic       exp_rdy;
    logic       pending;
    int         idx;
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hF0;
    if8.load_data  = words[0];
    if8.load_valid = 1'b1;
    tick();
    idx = 1;
    if8.load_data = words[1];
    pending = 1'b0;
    for (int c = 0; c < 3 * L8; c++) begin
      if (pending) begin
        idx++;
        if (idx < 3) if8.load_data = words[idx];
        else         if8.load_valid = 1'b0;
      end
      exp_rdy = (c == 0) || (c == L8) || (c >= 2 * L8);
      pending = if8.load_valid && exp_rdy;
      n_vec++; if (if8.data !== bit8(words[c / L8], c % L8) || if8.bit_valid !== 1'b1) begin
        n_err++; $display("FAIL b2b_data c=%0d got d=%b v=%b want d=%b v=1", c, if8.data, if8.bit_valid, bit8(words[c / L8], c % L8));
      end
      n_vec++; if (if8.done !== ((c % L8) == L8 - 1)) begin
        n_err++; $display("FAIL b2b_done c=%0d got %b want %b", c, if8.done, ((c % L8) == L8 - 1));
      end
      n_vec++; if (if8.load_ready !== exp_rdy) begin
        n_err++; $display("FAIL b2b_ready c=%0d got %b want %b", c, if8.load_ready, exp_rdy);
      end
      tick();
    end
    n_vec++; if ({if8.data, if8.bit_valid, if8.busy, if8.load_ready} !== 4'b0001) begin
      n_err++; $display("FAIL b2b_idle got %b want 0001", {if8.data, if8.bit_valid, if8.busy, if8.load_ready});
    end
  endtask

  // reset during the third bit of A5 with 3C buffered: nothing resumes afterwards
  task automatic test_reset_midword();
    if8.load_data  = 8'hA5;
    if8.load_valid = 1'b1;
    tick();
    if8.load_data = 8'h3C;
    tick();
    if8.load_valid = 1'b0;
    tick();
    n_vec++; if (if8.data !== 1'b1 || if8.load_ready !== 1'b0 || if8.busy !== 1'b1) begin
      n_err++; $display("FAIL midword_pre got d=%b r=%b b=%b want d=1 r=0 b=1", if8.data, if8.load_ready, if8.busy);
    end
    rst = 1'b0;
    #1;
    n_vec++; if ({if8.data, if8.bit_valid, if8.busy, if8.done, if8.load_ready} !== 5'b00001) begin
      n_err++; $display("FAIL midword_rst got %b want 00001", {if8.data, if8.bit_valid, if8.busy, if8.done, if8.load_ready});
    end
    tick();
    tick();
    rst = 1'b1;
    for (int c = 0; c < 2 * L8; c++) begin
      tick();
      n_vec++; if ({if8.data, if8.bit_valid, if8.busy, if8.done, if8.load_ready} !== 5'b00001) begin
        n_err++; $display("FAIL midword_after c=%0d got %b want 00001", c, {if8.data, if8.bit_valid, if8.busy, if8.done, if8.load_ready});
      end
    end
  endtask

  initial begin
    if8.load_data  = '0;
    if8.load_valid = 1'b0;
    if5.load_data  = '0;
    if5.load_valid = 1'b0;
    test_reset();
    test_single5();
    test_single8(8'h07);
    test_back_to_back();
    test_reset_midword();
    test_single8(8'h81);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
